dm_arbiter: RTL
===============

# dm_arbiter

Two-port arbiter and sequencer in front of the byte-addressed data memory `DM`. It shares `DM` between the pipeline MEM stage (port 0) and a debug/DMA port (port 1), which may issue word bursts. Each accepted access is registered and driven onto `DM` for one full cycle, so the negedge write and the combinational read both see stable command inputs. Read data is captured and returned with a one-cycle acknowledge pulse.

## Interface
- `BURST_MAX`, default 4: maximum port-1 burst length in words; `p1_len` is interpreted modulo this value, and 0 means 1 beat.
- `P0_PRIO`, default 1: 1 means port 0 always wins a tie; 0 means round-robin on ties.
- `clk` in 1: single clock.
- `rstn` in 1: asynchronous reset, active-low.
- `p0_req` in 1: port-0 request, held until `p0_ack`.
- `p0_we` in 2: store code (`DMWR_*`).
- `p0_re` in 3: load code (`DMRE_*`).
- `p0_addr` in 10: byte address.
- `p0_wdata` in 32: store data.
- `p0_ack` out 1: one-cycle completion pulse.
- `p0_rdata` out 32: load result, valid while `p0_ack`=1.
- `p1_req`, `p1_we`, `p1_re`, `p1_addr`, `p1_wdata`, `p1_ack`, `p1_rdata`: same meaning as the port-0 signals, for port 1.
- `p1_len` in 2: burst length minus 1.
- `dm_wr` out 2, `dm_re` out 3, `dm_addr` out 10, `dm_din` out 32: command to `DM`.
- `dm_dout` in 32: `DM` read data.
- `err` out 1: misaligned-access flag (see Configuration).

## Operation
- FSM states: IDLE, ACC0, ACC1, BURST.
- IDLE: with no request, `dm_wr`=`DMWR_NOP` and `dm_re`=`DMRE_NOP`.
  - If only one `pX_req` is high, that port wins.
  - If both are high, port 0 wins when `P0_PRIO`=1; otherwise the port not served last wins (`last` flag, reset value 0, so port 1 wins the first tie).
- Grant: the winner's command is registered into `dm_*`. The next state is ACC0, or ACC1 when `p1_len`=0, or BURST when `p1_len`>0.
- ACC0/ACC1: `DM` performs the access during this cycle. At the next posedge:
  - `dm_dout` is latched into `pX_rdata`.
  - `pX_ack` pulses.
  - The FSM returns to IDLE.
- BURST (port 1 only): beat counter loads `p1_len`.
  - Each beat forces `DMWR_SW`/`DMRE_LW` when `p1_we`/`p1_re` is non-NOP; sub-word burst codes are promoted to word.
  - `dm_addr` increments by 4 per beat, wrapping modulo 1024.
  - `p1_ack` pulses once per beat with that beat's `rdata`. The requester presents the next beat's `p1_wdata` on the cycle after each ack.
  - The FSM leaves BURST after the final beat. Port 0 is locked out for the whole burst.
- A command with both `we` and `re` NOP still takes a slot and acks with `rdata`=0.
- A request deasserted before its grant is dropped without side effects. Deassertion after grant is ignored; the access completes.
- Reset (any time, including mid-burst): state goes to IDLE; `dm_wr`/`dm_re` go to NOP; `dm_addr`, `dm_din`, `pX_rdata` go to 0; `pX_ack`, `err`, `last` go to 0. An in-flight write whose negedge has not yet occurred is suppressed.

## Timing
- Request sampled at posedge N → command on `DM` through cycle N+1 → write commits at the negedge inside N+1 → `ack`/`rdata` at posedge N+2.
- Single-access latency is 2 cycles; the back-to-back throughput ceiling is one access per 2 cycles.
- A burst of L beats occupies L+1 cycles after grant, with acks at N+2 … N+L+1.
- A new grant is evaluated in the cycle after the last ack (IDLE lasts at least one cycle).

## Configuration
- `DM_ARB_ALIGN_CHK_EN` defined: in IDLE, a winning request is rejected when:
  - a word access has `addr[1:0]`≠0, or
  - a half-word access has `addr[0]`≠0.
- On rejection:
  - `dm_*` stays NOP;
  - the winner gets `ack` with `rdata`=0 two cycles later;
  - `err` pulses together with that `ack`.
- Undefined: no check; `err` is tied to 0 and misaligned accesses pass through unchanged.

## Structure
- `DMWR_*`/`DMRE_*` encodings come from `ctrl_encode_def.v`.
- Add the FSM state codes `DMARB_IDLE`, `DMARB_ACC0`, `DMARB_ACC1`, `DMARB_BURST` there as well.
- One natural sub-module: `dm_arb_pick`, the combinational priority/round-robin selector (inputs: reqs, `last`, `P0_PRIO`; output: grant index).

## Test plan
- Reset, then a port-0 `SW` with addr 0x10 and data 0xDEADBEEF, then a port-0 `LW` from 0x10 → second `p0_ack` with `p0_rdata`=0xDEADBEEF at request+2 cycles.
- Simultaneous `p0_req`/`p1_req`, `P0_PRIO`=0, three rounds → grants go P1, P0, P1; with `P0_PRIO`=1, port 0 wins all three.
- Port-1 burst write with `p1_len`=3 at 0x3F8, data 1,2,3,4 → words land at 0x3F8, 0x3FC, 0x000, 0x004 (wrap); four `p1_ack` pulses; port 0 held off until after the 4th.
- Port-0 `LB` at 0x21 with byte 0x80 → `rdata` 0xFFFFFF80; `LBU` → 0x00000080.
- `rstn` low mid-burst after beat 1 → outputs reach their reset values immediately; beats 2–4 are never written.
- With `DM_ARB_ALIGN_CHK_EN`: `SW` at 0x12 → `err` and `ack` pulse together, memory unchanged. Without it: the write proceeds and `err` stays 0.

Source files
------------

// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the DM arbiter: DM command codes, arbiter FSM state
// codes and the access-alignment predicate.
package dm_arbiter_pkg;

  localparam logic [1:0] DMWR_NOP = 2'd0;
  localparam logic [1:0] DMWR_SB  = 2'd1;
  localparam logic [1:0] DMWR_SH  = 2'd2;
  localparam logic [1:0] DMWR_SW  = 2'd3;

  localparam logic [2:0] DMRE_NOP = 3'd0;
  localparam logic [2:0] DMRE_LB  = 3'd1;
  localparam logic [2:0] DMRE_LBU = 3'd2;
  localparam logic [2:0] DMRE_LH  = 3'd3;
  localparam logic [2:0] DMRE_LHU = 3'd4;
  localparam logic [2:0] DMRE_LW  = 3'd5;

  typedef enum logic [1:0] {
    DMARB_IDLE  = 2'd0,
    DMARB_ACC0  = 2'd1,
    DMARB_ACC1  = 2'd2,
    DMARB_BURST = 2'd3
  } dmarb_state_e;

  function automatic logic is_misaligned(input logic [1:0] wr, input logic [2:0] re,
                                         input logic [1:0] a);
    logic word_s;
    logic half_s;
    word_s = (wr == DMWR_SW) || (re == DMRE_LW);
    half_s = (wr == DMWR_SH) || (re == DMRE_LH) || (re == DMRE_LHU);
    return (word_s && (a != 2'd0)) || (half_s && a[0]);
  endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational two-port grant selector: fixed port-0 priority or
// round-robin on ties, steered by the port served last.
module dm_arb_pick #(
  parameter int P0_PRIO = 1
) (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       gnt
);

  // Grant decode; on a round-robin tie the port not served last wins.
  always_comb begin
    valid = req[0] | req[1];
    gnt   = 1'b0;
    case (req)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = (P0_PRIO != 0) ? 1'b0 : ~last;
      default: gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer in front of the byte-addressed data memory.
// Optional build macro: DM_ARB_ALIGN_CHK_EN (reject misaligned winners, pulse err).
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int BURST_MAX = 4,
  parameter int P0_PRIO   = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        p0_req,
  input  logic [1:0]  p0_we,
  input  logic [2:0]  p0_re,
  input  logic [9:0]  p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic [1:0]  p1_we,
  input  logic [2:0]  p1_re,
  input  logic [9:0]  p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [1:0]  p1_len,
  output logic        p1_ack,
  output logic [31:0] p1_rdata,
  output logic [1:0]  dm_wr,
  output logic [2:0]  dm_re,
  output logic [9:0]  dm_addr,
  output logic [31:0] dm_din,
  input  logic [31:0] dm_dout,
  output logic        err
);

  dmarb_state_e state_r, state_s;
  logic         last_r, first_r, rej_r, err_r;
  logic [1:0]   cnt_r, len_s;
  logic [31:0]  din_r, rd_s;
  logic         valid_s, gnt_s, rej_s;
  logic [1:0]   cmd_wr_s;
  logic [2:0]   cmd_re_s;
  logic [9:0]   cmd_addr_s;
  logic [31:0]  cmd_wdata_s;

  dm_arb_pick #(.P0_PRIO(P0_PRIO)) u_pick (
    .req   ({p1_req, p0_req}),
    .last  (last_r),
    .valid (valid_s),
    .gnt   (gnt_s)
  );

  // Burst beats after the first take store data straight from the requester,
  // who updates it in the cycle each ack is visible, ahead of the negedge write.
  assign dm_din = ((state_r == DMARB_BURST) && !first_r) ? p1_wdata : din_r;
  assign err    = err_r;

  // Winner's command, burst promotion to word codes, and alignment verdict.
  always_comb begin
    cmd_wr_s    = DMWR_NOP;
    cmd_re_s    = DMRE_NOP;
    cmd_addr_s  = 10'd0;
    cmd_wdata_s = 32'd0;
    rej_s       = 1'b0;
    len_s       = 2'(int'(p1_len) % BURST_MAX);
    if (gnt_s) begin
      cmd_addr_s  = p1_addr;
      cmd_wdata_s = p1_wdata;
      if (len_s != 2'd0) begin
        cmd_wr_s = (p1_we != DMWR_NOP) ? DMWR_SW : DMWR_NOP;
        cmd_re_s = (p1_re != DMRE_NOP) ? DMRE_LW : DMRE_NOP;
      end else begin
        cmd_wr_s = p1_we;
        cmd_re_s = p1_re;
      end
    end else begin
      cmd_wr_s    = p0_we;
      cmd_re_s    = p0_re;
      cmd_addr_s  = p0_addr;
      cmd_wdata_s = p0_wdata;
    end
`ifdef DM_ARB_ALIGN_CHK_EN
    rej_s = is_misaligned(cmd_wr_s, cmd_re_s, cmd_addr_s[1:0]);
`else
    rej_s = 1'b0;
`endif
  end

  // Next-state logic; a rejected winner still takes a single ack slot.
  always_comb begin
    state_s = state_r;
    rd_s    = (dm_re == DMRE_NOP) ? 32'd0 : dm_dout;
    case (state_r)
      DMARB_IDLE: begin
        if (!valid_s)                               state_s = DMARB_IDLE;
        else if (!gnt_s)                            state_s = DMARB_ACC0;
        else if ((len_s == 2'd0) || rej_s)          state_s = DMARB_ACC1;
        else                                        state_s = DMARB_BURST;
      end
      DMARB_ACC0:  state_s = DMARB_IDLE;
      DMARB_ACC1:  state_s = DMARB_IDLE;
      DMARB_BURST: state_s = (cnt_r == 2'd0) ? DMARB_IDLE : DMARB_BURST;
      default:     state_s = DMARB_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_r <= DMARB_IDLE;
    else       state_r <= state_s;
  end

  // Command registers, beat counter, acks and captured read data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dm_wr    <= DMWR_NOP;
      dm_re    <= DMRE_NOP;
      dm_addr  <= 10'd0;
      din_r    <= 32'd0;
      p0_ack   <= 1'b0;
      p1_ack   <= 1'b0;
      p0_rdata <= 32'd0;
      p1_rdata <= 32'd0;
      err_r    <= 1'b0;
      last_r   <= 1'b0;
      first_r  <= 1'b0;
      rej_r    <= 1'b0;
      cnt_r    <= 2'd0;
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        DMARB_IDLE: begin
          if (valid_s) begin
            last_r  <= gnt_s;
            cnt_r   <= len_s;
            first_r <= 1'b1;
            rej_r   <= rej_s;
            dm_wr   <= rej_s ? DMWR_NOP : cmd_wr_s;
            dm_re   <= rej_s ? DMRE_NOP : cmd_re_s;
            if (!rej_s) begin
              dm_addr <= cmd_addr_s;
              din_r   <= cmd_wdata_s;
            end else begin
              dm_addr <= dm_addr;
              din_r   <= din_r;
            end
          end else begin
            dm_wr <= DMWR_NOP;
            dm_re <= DMRE_NOP;
          end
        end
        DMARB_ACC0: begin
          p0_ack   <= 1'b1;
          p0_rdata <= rd_s;
          err_r    <= rej_r;
          dm_wr    <= DMWR_NOP;
          dm_re    <= DMRE_NOP;
        end
        DMARB_ACC1: begin
          p1_ack   <= 1'b1;
          p1_rdata <= rd_s;
          err_r    <= rej_r;
          dm_wr    <= DMWR_NOP;
          dm_re    <= DMRE_NOP;
        end
        DMARB_BURST: begin
          p1_ack   <= 1'b1;
          p1_rdata <= rd_s;
          first_r  <= 1'b0;
          if (cnt_r == 2'd0) begin
            dm_wr <= DMWR_NOP;
            dm_re <= DMRE_NOP;
          end else begin
            cnt_r   <= cnt_r - 2'd1;
            dm_addr <= dm_addr + 10'd4;
          end
        end
        default: begin
          dm_wr <= DMWR_NOP;
          dm_re <= DMRE_NOP;
        end
      endcase
    end
  end

endmodule
